cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Sequences the pipelined CPU for the debug unit: turns the run switch and the step button into a one-cycle-wide CPU clock-enable (cpu_en).
- Supports free-run, single-step and a hardware PC breakpoint.
- Keeps a retired-cycle counter for the debug display.
- Sits between the board inputs and the CPU clock gating in the debug unit; the CPU advances only in cycles where cpu_en=1.

Parameters:
- DB_CYCLES, 16'd50000: number of consecutive clk cycles a synchronized input must differ from its debounced level before the level flips (minimum 2).
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- run  input  1  raw run switch (level, asynchronous)
- step  input  1  raw step button (asynchronous)
- pc  input  32  current IF-stage PC from CPU
- bp_addr  input  32  breakpoint address
- bp_en  input  1  breakpoint enable
- cpu_en  output  1  CPU clock-enable; the CPU advances one cycle per high clk cycle
- running  output  1  1 while in RUN state
- bp_hit  output  1  sticky; the last halt was caused by the breakpoint
- cycle_cnt  output  CNT_W  number of cpu_en cycles since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - cpu_en=0, running=0, bp_hit=0, cycle_cnt=0.
  - State HALT, both debounced levels 0, sync flops 0, debounce counters 0.
  - bp_lock=0, first=0.
- Input conditioning, per input:
  - 2-flop synchronizer.
  - Debounce counter: cleared whenever sync==db. Otherwise it increments. When it has counted DB_CYCLES consecutive differing cycles, db takes sync on the next edge and the counter clears.
  - step_pulse = db_step & ~db_step_q. It is exactly 1 cycle per press.
  - run_db is used as a level.
- State machine (registered, one state per clk), states HALT, RUN:
  - HALT:
    - cpu_en=0 except on step.
    - step_pulse → cpu_en=1 for exactly the next cycle; clears bp_hit and bp_lock. This is the single-step; no state change.
    - run_db=1 and bp_lock=0 → go to RUN, set first=1.
    - If step_pulse and the RUN condition coincide, the step is taken that cycle and RUN is entered the cycle after.
  - RUN:
    - cpu_en=1 every cycle; running=1.
    - run_db=0 → HALT. cpu_en is 0 from the next cycle; the current cycle still counts.
    - Breakpoint: bp_en=1, first=0 and pc==bp_addr → HALT with cpu_en=0 in that same cycle (combinational gate), so the instruction at bp_addr is not fetched past. Sets bp_hit=1 and bp_lock=1.
    - first is cleared after the first RUN cycle. The instruction at bp_addr therefore executes when resuming from it.
    - bp_lock clears when run_db=0 or on step_pulse. The user must toggle run off/on or step to resume.
- Counting: cycle_cnt increments by 1 in each cycle with cpu_en=1 and wraps from all-ones to 0.
- bp_en changes take effect immediately; bp_en=0 never sets bp_hit.
- rst asserted mid-RUN or mid-step: all state returns to reset values on the next edge, and cpu_en=0 that cycle.

Test Plan (DB_CYCLES=4):
- Reset: assert rst 3 cycles with run=1 → cpu_en=0, running=0, cycle_cnt=0 throughout.
- Step: press step for 10 cycles, including 2-cycle bounces (1,0,1) before stable → exactly one cpu_en pulse, and cycle_cnt=1. A second press gives cycle_cnt=2.
- Run then stop: run=1 for 20 cycles after debounce, then run=0 → cpu_en=1 continuously in RUN, cycle_cnt equals the number of cpu_en cycles (checked against the scoreboard), running falls 2+4+1 cycles after run falls.
- Breakpoint: bp_en=1, bp_addr=0x0000_0010, pc stepping 0x0,0x4,0x8… under cpu_en → when pc=0x10, cpu_en=0 that same cycle, bp_hit=1, running=0, and the machine stays halted with run still 1.
- Resume: from the breakpoint, toggle run 0→1 → RUN restarts, cpu_en=1 on the first cycle with pc=0x10 (no re-trigger), and bp_hit clears only on step. Alternatively, a step from the breakpoint → one pulse, bp_hit=0.
- Wrap: CNT_W=4, 17 steps → cycle_cnt=1.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Debug-unit run/step sequencer: turns board switches into a one-cycle CPU clock-enable,
// with a hardware PC breakpoint and a retired-cycle counter.

module cpu_run_ctrl_db #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);
    logic        s1_q, s2_q, db_q, db_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // The edge on which cnt_q reaches DB_CYCLES-1 is the DB_CYCLES-th differing cycle.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q >= DB_CYCLES - 16'd1) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign level_o = db_q;
endmodule

module cpu_run_ctrl #(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    output logic             cpu_en,
    output logic             running,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);
    // state   | meaning
    // ST_HALT | CPU frozen; single steps allowed
    // ST_RUN  | CPU enabled every cycle until run drops or breakpoint
    typedef enum logic {ST_HALT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic             run_db, step_db, step_db_q, step_pulse, bp_trig;
    logic             step_q, step_d, first_q, first_d;
    logic             bp_hit_q, bp_hit_d, bp_lock_q, bp_lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    cpu_run_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk(clk), .rst(rst), .raw_i(run), .level_o(run_db)
    );
    cpu_run_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk(clk), .rst(rst), .raw_i(step), .level_o(step_db)
    );

    assign step_pulse = step_db & ~step_db_q;
    assign bp_trig    = (state_q == ST_RUN) && bp_en && !first_q && (pc == bp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HALT;
            step_db_q <= 1'b0;
            step_q    <= 1'b0;
            first_q   <= 1'b0;
            bp_hit_q  <= 1'b0;
            bp_lock_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            step_db_q <= step_db;
            step_q    <= step_d;
            first_q   <= first_d;
            bp_hit_q  <= bp_hit_d;
            bp_lock_q <= bp_lock_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = 1'b0;
        first_d   = first_q;
        bp_hit_d  = bp_hit_q;
        bp_lock_d = bp_lock_q;
        cpu_en    = 1'b0;
        running   = 1'b0;
        if (step_pulse) begin
            bp_hit_d  = 1'b0;
            bp_lock_d = 1'b0;
        end
        if (!run_db) begin
            bp_lock_d = 1'b0;
        end
        case (state_q)
            ST_HALT: begin
                cpu_en = step_q;
                // A step that coincides with the run condition delays entry to RUN by one cycle.
                if (step_pulse) begin
                    step_d = 1'b1;
                end else if (run_db && !bp_lock_q) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                running = 1'b1;
                first_d = 1'b0;
                if (bp_trig) begin
                    state_d   = ST_HALT;
                    bp_hit_d  = 1'b1;
                    bp_lock_d = 1'b1;
                end else begin
                    cpu_en = 1'b1;
                    if (!run_db) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
        if (rst) begin
            cpu_en = 1'b0;
        end
        cnt_d = cpu_en ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cnt_q;
endmodule
